// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core control path: PC sequencer state and the
// machine word.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  typedef logic [31:0] word_t;

  // Wide enough for the largest reset hold of 15 cycles.
  localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/redirect_latch.sv
// Remembers a jump or taken branch that could not be applied because the PC
// was stalled. A jump always supersedes a branch.
module redirect_latch
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  logic jump,
  input  logic branch_taken,
  input  logic set_en,
  input  logic clear,
  output logic req_j,
  output logic req_b
);

  logic pend_j_q, pend_j_d;
  logic pend_b_q, pend_b_d;

  assign req_j = jump | pend_j_q;
  assign req_b = (branch_taken | pend_b_q) & ~req_j;

  always_comb begin
    pend_j_d = pend_j_q;
    pend_b_d = pend_b_q;
    if (clear) begin
      pend_j_d = 1'b0;
      pend_b_d = 1'b0;
    end else if (set_en) begin
      // Storing the resolved requests means a later jump drops an older branch.
      pend_j_d = req_j;
      pend_b_d = req_b;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pend_j_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      pend_j_q <= pend_j_d;
      pend_b_q <= pend_b_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Decides each cycle whether the PC advances and along which path, holding
// redirects across fetch/data stalls and stopping for good on halt.
module pc_sequencer
  import cpu_types_pkg::*;
#(
  parameter int RESET_HOLD = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  logic  load_use,
  input  logic  jump,
  input  logic  branch_taken,
  input  logic  halt,
  output logic  imemREN,
  output logic  pcEN,
  output logic  jumpmux,
  output logic  branchmux,
  output logic  hold_redirect,
  output logic  flush_ifid,
  output logic  halted,
  output word_t fetch_cnt
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_INIT = HOLD_CNT_W'(RESET_HOLD - 1);

  seq_state_t             state_q, state_d;
  logic [HOLD_CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  word_t                  fetch_cnt_q, fetch_cnt_d;

  logic dwait, adv;
  logic req_j, req_b;
  logic pend_set, pend_clr;

  // A data-memory stall beats a returning instruction word.
  assign dwait = (dmemREN | dmemWEN) & ~dhit;
  assign adv   = ihit & ~dwait & ~load_use;

  redirect_latch u_redirect_latch (
    .CLK          (CLK),
    .nRST         (nRST),
    .jump         (jump),
    .branch_taken (branch_taken),
    .set_en       (pend_set),
    .clear        (pend_clr),
    .req_j        (req_j),
    .req_b        (req_b)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    fetch_cnt_d   = fetch_cnt_q;
    imemREN       = 1'b0;
    pcEN          = 1'b0;
    jumpmux       = 1'b0;
    branchmux     = 1'b0;
    hold_redirect = 1'b0;
    flush_ifid    = 1'b0;
    halted        = 1'b0;
    pend_set      = 1'b0;
    pend_clr      = 1'b0;

    unique case (state_q)
      HOLD: begin
        if (hold_cnt_q == '0) state_d = RUN;
        else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end
      RUN: begin
        imemREN = 1'b1;
        if (halt) begin
          state_d  = HALTED;
          pend_clr = 1'b1;
        end else begin
          pcEN          = adv;
          jumpmux       = adv & req_j;
          branchmux     = adv & req_b;
          flush_ifid    = adv & (req_j | req_b);
          hold_redirect = ~adv & (req_j | req_b);
          pend_set      = ~adv;
          pend_clr      = adv;
          if (adv) fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
      end
      HALTED: halted = 1'b1;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= HOLD;
      hold_cnt_q  <= HOLD_INIT;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized check of pc_sequencer against a cycle-level
// behavioural model of the PC sequencing rules.
module tb_pc_sequencer;
  import cpu_types_pkg::*;

  localparam int RH = 2;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  ihit, dhit, dmemREN, dmemWEN, load_use, jump, branch_taken, halt;
  logic  imemREN, pcEN, jumpmux, branchmux, hold_redirect, flush_ifid, halted;
  word_t fetch_cnt;

  pc_sequencer #(.RESET_HOLD(RH)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ihit          (ihit),
    .dhit          (dhit),
    .dmemREN       (dmemREN),
    .dmemWEN       (dmemWEN),
    .load_use      (load_use),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .halt          (halt),
    .imemREN       (imemREN),
    .pcEN          (pcEN),
    .jumpmux       (jumpmux),
    .branchmux     (branchmux),
    .hold_redirect (hold_redirect),
    .flush_ifid    (flush_ifid),
    .halted        (halted),
    .fetch_cnt     (fetch_cnt)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: cycles since reset, sticky halt, which redirect is
  // waiting (0 none, 1 jump, 2 branch) and the number of PC advances.
  int    m_since;
  bit    m_halted;
  int    m_pend;
  word_t m_cnt;

  task automatic check_all_zero(input string tag);
    check({tag, "_imem"},  32'(imemREN), 0);
    check({tag, "_pcen"},  32'(pcEN), 0);
    check({tag, "_jmux"},  32'(jumpmux), 0);
    check({tag, "_bmux"},  32'(branchmux), 0);
    check({tag, "_hold"},  32'(hold_redirect), 0);
    check({tag, "_flush"}, 32'(flush_ifid), 0);
    check({tag, "_halted"},32'(halted), 0);
    check({tag, "_cnt"},   fetch_cnt, 0);
  endtask

  // Enter at a negedge with nRST still high; leaves at a negedge out of reset.
  task automatic do_reset();
    #2 nRST = 1'b0;
    #1 check_all_zero("rst");
    @(negedge CLK);
    {ihit, dhit, dmemREN, dmemWEN, load_use, jump, branch_taken, halt} = '0;
    @(negedge CLK);
    nRST     = 1'b1;
    m_since  = 0;
    m_halted = 1'b0;
    m_pend   = 0;
    m_cnt    = '0;
  endtask

  // One clock cycle: drive at the negedge, compare mid-phase, update the model
  // at the rising edge.
  task automatic step(input logic ih, dh, rd, wr, lu, j, b, h);
    bit run, busy, go, want_j, want_b;
    ihit = ih; dhit = dh; dmemREN = rd; dmemWEN = wr;
    load_use = lu; jump = j; branch_taken = b; halt = h;
    #2;
    run    = !m_halted && (m_since >= RH);
    busy   = (rd || wr) && !dh;
    go     = run && !h && ih && !busy && !lu;
    want_j = j || (m_pend == 1);
    want_b = !want_j && (b || (m_pend == 2));
    check("imemREN",       32'(imemREN),       32'(run));
    check("pcEN",          32'(pcEN),          32'(go));
    check("jumpmux",       32'(jumpmux),       32'(go && want_j));
    check("branchmux",     32'(branchmux),     32'(go && want_b));
    check("flush_ifid",    32'(flush_ifid),    32'(go && (want_j || want_b)));
    check("hold_redirect", 32'(hold_redirect), 32'(run && !h && !go && (want_j || want_b)));
    check("halted",        32'(halted),        32'(m_halted));
    check("fetch_cnt",     fetch_cnt,          m_cnt);
    @(posedge CLK);
    if (m_halted) begin
      // sticky
    end else if (!run) begin
      m_since++;
    end else if (h) begin
      m_halted = 1'b1;
      m_pend   = 0;
    end else if (go) begin
      m_pend = 0;
      m_cnt  = m_cnt + 1;
    end else if (want_j) begin
      m_pend = 1;
    end else if (want_b) begin
      m_pend = 2;
    end
    @(negedge CLK);
  endtask

  task automatic idle(input logic ih);
    step(ih, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    word_t c0;
    nRST = 1'b1;
    {ihit, dhit, dmemREN, dmemWEN, load_use, jump, branch_taken, halt} = '0;
    @(negedge CLK);
    do_reset();

    // Reset release with ihit held high: first advance in cycle RH.
    repeat (RH + 1) idle(1);
    check("first_cnt", fetch_cnt, 1);

    // Data read stalls three cycles, then completes.
    c0 = m_cnt;
    repeat (3) step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    check("dwait_cnt", fetch_cnt, c0 + 1);
    step(1, 1, 0, 1, 0, 0, 0, 0);   // write hit
    step(1, 1, 0, 0, 0, 0, 0, 0);   // stray dhit ignored

    // Branch held across two ihit misses, applied on the hit.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(0);
    idle(0);
    idle(1);
    idle(0);                         // nothing left pending

    // Jump and branch together: jump wins, branch not kept.
    step(1, 0, 0, 0, 0, 1, 1, 0);
    idle(0);
    step(0, 0, 0, 0, 0, 1, 1, 0);    // stalled: only the jump is kept
    step(1, 0, 0, 0, 1, 0, 0, 0);    // load_use keeps it pending
    idle(1);

    // Halt with jump and ihit: no advance, sticky halt, counter frozen.
    c0 = m_cnt;
    step(1, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) step(1'(i), 0, 0, 0, 0, 1'(i >> 1), 1, 0);
    check("halt_cnt", fetch_cnt, c0);
    check("halt_sticky", 32'(halted), 1);

    // Counter wrap from a preloaded value.
    do_reset();
    repeat (RH) idle(0);
    dut.fetch_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    idle(1);
    check("wrap_cnt", fetch_cnt, 0);

    // Reset lands while a branch is pending.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    branch_taken = 1'b1;
    do_reset();
    repeat (RH) idle(0);
    idle(0);                         // no stale redirect after reset

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 149) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
